// File: rtl/ahb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_pkg
// Description : Shared AHB encodings, FSM states and helpers for ahb_slave_if.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } state_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Wait counter width: enough for TIMEOUT_CYCLES, clamped to 8..16 bits.
    function automatic int timeout_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_if_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if_if
// Description : AHB-Lite slave port plus simple register-bus signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_slave_if_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  hSSel;
    logic [31:0]           hSAddr;
    logic [1:0]            hSTrans;
    logic                  hSWrite;
    logic [2:0]            hSSize;
    logic [2:0]            hSBurst;
    logic [31:0]           hSWData;
    logic                  hSReadyIn;
    logic                  hSReadyOut;
    logic [1:0]            hSResp;
    logic [31:0]           hSRData;
    logic [ADDR_WIDTH-1:0] regAddr;
    logic                  regRead;
    logic                  regWrite;
    logic [3:0]            regByteEn;
    logic [31:0]           regWData;
    logic [31:0]           regRData;
    logic                  regReady;
    logic                  regError;
    logic                  timeoutEvent;

    modport slave (
        input  hSSel, hSAddr, hSTrans, hSWrite, hSSize, hSBurst, hSWData, hSReadyIn,
        input  regRData, regReady, regError,
        output hSReadyOut, hSResp, hSRData,
        output regAddr, regRead, regWrite, regByteEn, regWData, timeoutEvent
    );

    modport master (
        output hSSel, hSAddr, hSTrans, hSWrite, hSSize, hSBurst, hSWData, hSReadyIn,
        output regRData, regReady, regError,
        input  hSReadyOut, hSResp, hSRData,
        input  regAddr, regRead, regWrite, regByteEn, regWData, timeoutEvent
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_if_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_bytelane
// Description : HSIZE/address to byte-enable decoder with illegal-access flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_bytelane
    import ahb_slave_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] byte_en_o,
    output logic       illegal_o
);

    always_comb begin
        byte_en_o = 4'b0000;
        illegal_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: byte_en_o = 4'b0001 << addr_i;
            HSIZE_HALF: begin
                byte_en_o = addr_i[1] ? 4'b1100 : 4'b0011;
                illegal_o = addr_i[0];
            end
            HSIZE_WORD: begin
                byte_en_o = 4'b1111;
                illegal_o = |addr_i;
            end
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if
// Description : AHB-Lite slave to single-access register bus bridge with
//               wait-state insertion and two-cycle ERROR response.
//               Optional data-phase timeout: RW_AHBS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_if
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           macPIClk,
    input  logic           macPIClkHardRst,
    ahb_slave_if_if.slave  bus
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [3:0]            be_q;
    logic                  w_accept;
    logic                  w_illegal;
    logic [3:0]            w_be;
    logic                  w_timeout;

    ahb_slave_bytelane u_bytelane (
        .size_i    (bus.hSSize),
        .addr_i    (bus.hSAddr[1:0]),
        .byte_en_o (w_be),
        .illegal_o (w_illegal)
    );

    assign w_accept = bus.hSSel && trans_active(bus.hSTrans) && bus.hSReadyIn;

`ifdef RW_AHBS_TIMEOUT_EN
    localparam int              CNT_W      = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             tmo_q;

    // Fires in the last permitted wait cycle so the strobe drops right after it.
    assign w_timeout = (state_q == ST_ACCESS) && !bus.regReady && (wait_cnt_q == C_TMO_LAST);

    always_ff @(posedge macPIClk or posedge macPIClkHardRst) begin
        if (macPIClkHardRst) begin
            wait_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            if (w_accept)
                wait_cnt_q <= '0;
            else if ((state_q == ST_ACCESS) && !bus.regReady)
                wait_cnt_q <= wait_cnt_q + 1'b1;
            tmo_q <= w_timeout;
        end
    end

    assign bus.timeoutEvent = tmo_q;
`else
    logic w_unused_tmo;
    assign w_unused_tmo     = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
    assign bus.timeoutEvent = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{bus.hSBurst, bus.hSAddr[31:ADDR_WIDTH]};

    always_ff @(posedge macPIClk or posedge macPIClkHardRst) begin
        if (macPIClkHardRst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                addr_q  <= bus.hSAddr[ADDR_WIDTH-1:0];
                write_q <= bus.hSWrite;
                be_q    <= w_be;
            end
        end
    end

    assign bus.regAddr   = addr_q;
    assign bus.regByteEn = be_q;

    always_comb begin
        state_d        = state_q;
        bus.hSReadyOut = 1'b1;
        bus.hSResp     = HRESP_OKAY;
        bus.hSRData    = 32'h0;
        bus.regRead    = 1'b0;
        bus.regWrite   = 1'b0;
        bus.regWData   = 32'h0;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2)
                    bus.hSResp = HRESP_ERROR;
                if (w_accept)
                    state_d = w_illegal ? ST_ERR1 : ST_ACCESS;
                else
                    state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                bus.regRead    = !write_q;
                bus.regWrite   = write_q;
                bus.regWData   = bus.hSWData;
                bus.hSReadyOut = bus.regReady && !bus.regError;
                if (bus.regReady && bus.regError) begin
                    state_d = ST_ERR1;
                end else if (bus.regReady) begin
                    bus.hSRData = write_q ? 32'h0 : bus.regRData;
                    if (w_accept)
                        state_d = w_illegal ? ST_ERR1 : ST_ACCESS;
                    else
                        state_d = ST_IDLE;
                end else if (w_timeout) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                bus.hSReadyOut = 1'b0;
                bus.hSResp     = HRESP_ERROR;
                state_d        = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_if
// Description : Scoreboard bench for ahb_slave_if (strobe and response queues).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_if;
    import ahb_slave_pkg::*;

    logic clk;
    logic rst;

    ahb_slave_if_if #(.ADDR_WIDTH(16)) bus ();

    ahb_slave_if #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .macPIClk        (clk),
        .macPIClkHardRst (rst),
        .bus             (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [63:0] sq[$];
    logic [63:0] rq[$];

    // Register-side responder: ready after cur_delay strobe cycles.
    int          cur_delay = 0;
    logic        cur_err   = 1'b0;
    logic [31:0] cur_rdata = 32'h0;
    int          wcnt      = 0;
    logic        strobe;

    assign strobe        = bus.regRead | bus.regWrite;
    assign bus.regReady  = strobe && (wcnt >= cur_delay);
    assign bus.regError  = bus.regReady && cur_err;
    assign bus.regRData  = cur_rdata;
    assign bus.hSReadyIn = bus.hSReadyOut;

    always @(posedge clk) wcnt <= (strobe && !bus.regReady) ? wcnt + 1 : 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: compares strobes and data-phase completions against the queues.
    logic dphase  = 1'b0;
    int   mwaits  = 0;
    logic mtmo    = 1'b0;
    int   run     = 0;
    int   max_run = 0;

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_ctrl", {38'd0, bus.hSReadyOut, bus.hSResp, bus.regRead, bus.regWrite,
                      bus.regByteEn, bus.timeoutEvent, bus.regAddr}, {38'd0, 1'b1, 25'd0});
                check("reset_data", {bus.hSRData, bus.regWData}, 64'h0);
                sq.delete();
                rq.delete();
                dphase = 1'b0;
                mwaits = 0;
                mtmo   = 1'b0;
                run    = 0;
            end else begin
                if (strobe) begin
                    run++;
                    if (run > max_run) max_run = run;
                    if (sq.size() == 0) begin
                        check("unexpected_strobe", {32'd0, bus.regAddr, bus.regByteEn, 12'd0}, 64'h0);
                    end else begin
                        e = sq.pop_front();
                        check("strobe", {10'd0, bus.regWrite, bus.regRead, bus.regAddr,
                              bus.regByteEn, bus.regWData}, e);
                    end
                end else begin
                    run = 0;
                end
                if (bus.timeoutEvent) mtmo = 1'b1;
                if (dphase) begin
                    if (bus.hSReadyOut) begin
                        if (rq.size() == 0) begin
                            check("unexpected_resp", 64'h1, 64'h0);
                        end else begin
                            e = rq.pop_front();
                            check("resp", {21'd0, bus.hSResp, bus.hSRData, 8'(mwaits), mtmo}, e);
                        end
                        mwaits = 0;
                        mtmo   = 1'b0;
                    end else begin
                        mwaits++;
                    end
                end
                if (bus.hSSel && bus.hSTrans[1] && bus.hSReadyOut) dphase = 1'b1;
                else if (bus.hSReadyOut)                            dphase = 1'b0;
            end
        end
    end

    // Issue one address phase (caller sits just after a rising edge) and
    // queue the hand-computed strobe and response expectations.
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] wd, input int dly, input logic er,
                         input logic [31:0] rd, input logic [3:0] be, input int nstb,
                         input logic [1:0] resp, input logic [31:0] erd,
                         input int waits, input logic tmo);
        logic rdy;
        bit   ok;
        for (int i = 0; i < nstb; i++)
            sq.push_back({10'd0, w, !w, a[15:0], be, (w ? wd : 32'h0)});
        rq.push_back({21'd0, resp, erd, 8'(waits), tmo});
        bus.hSSel   = 1'b1;
        bus.hSAddr  = a;
        bus.hSTrans = HTRANS_NONSEQ;
        bus.hSWrite = w;
        bus.hSSize  = sz;
        bus.hSBurst = 3'b000;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rdy = bus.hSReadyOut;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'h0, 64'h1);
        bus.hSSel   = 1'b0;
        bus.hSTrans = HTRANS_IDLE;
        bus.hSWData = w ? wd : 32'h0;
        cur_delay   = dly;
        cur_err     = er;
        cur_rdata   = rd;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (sq.size() == 0 && rq.size() == 0) break;
        end
        check("drain", {32'(sq.size()), 32'(rq.size())}, 64'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.hSSel   = 1'b0;
        bus.hSAddr  = 32'h0;
        bus.hSTrans = HTRANS_IDLE;
        bus.hSWrite = 1'b0;
        bus.hSSize  = HSIZE_WORD;
        bus.hSBurst = 3'b000;
        bus.hSWData = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word write, zero wait
        issue(32'h0000_0040, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 0, 1'b0, 32'h55AA_55AA,
              4'b1111, 1, HRESP_OKAY, 32'h0, 0, 1'b0);
        drain();
        // Byte read at 0x13, three wait states
        issue(32'h0000_0013, 1'b0, HSIZE_BYTE, 32'h0, 3, 1'b0, 32'h1234_5678,
              4'b1000, 4, HRESP_OKAY, 32'h1234_5678, 3, 1'b0);
        drain();
        // Misaligned halfword and oversize access: ERROR, no strobe
        issue(32'h0000_0001, 1'b0, HSIZE_HALF, 32'h0, 0, 1'b0, 32'h0,
              4'b0000, 0, HRESP_ERROR, 32'h0, 1, 1'b0);
        drain();
        issue(32'h0000_0000, 1'b1, 3'b011, 32'h1111_2222, 0, 1'b0, 32'h55AA_55AA,
              4'b0000, 0, HRESP_ERROR, 32'h0, 1, 1'b0);
        drain();
        // Halfword lanes
        issue(32'h0000_0010, 1'b1, HSIZE_HALF, 32'h0000_BEEF, 0, 1'b0, 32'h55AA_55AA,
              4'b0011, 1, HRESP_OKAY, 32'h0, 0, 1'b0);
        issue(32'h0000_0022, 1'b0, HSIZE_HALF, 32'h0, 1, 1'b0, 32'hA1B2_C3D4,
              4'b1100, 2, HRESP_OKAY, 32'hA1B2_C3D4, 1, 1'b0);
        drain();
        // Register-side error on a write, then a read accepted during ERR2
        issue(32'h0000_0080, 1'b1, HSIZE_WORD, 32'h0BAD_F00D, 1, 1'b1, 32'h55AA_55AA,
              4'b1111, 2, HRESP_ERROR, 32'h0, 3, 1'b0);
        issue(32'h0000_0084, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hCAFE_F00D,
              4'b1111, 1, HRESP_OKAY, 32'hCAFE_F00D, 0, 1'b0);
        drain();
        // Four back-to-back zero-wait reads: strobe run of exactly four
        max_run = 0;
        issue(32'h0000_0100, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0000_0100,
              4'b1111, 1, HRESP_OKAY, 32'h0000_0100, 0, 1'b0);
        issue(32'h0000_0104, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0000_0104,
              4'b1111, 1, HRESP_OKAY, 32'h0000_0104, 0, 1'b0);
        issue(32'h0000_0108, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0000_0108,
              4'b1111, 1, HRESP_OKAY, 32'h0000_0108, 0, 1'b0);
        issue(32'h0000_010C, 1'b0, HSIZE_BYTE, 32'h0, 0, 1'b0, 32'h0000_010C,
              4'b0001, 1, HRESP_OKAY, 32'h0000_010C, 0, 1'b0);
        drain();
        check("b2b_run", 64'(max_run), 64'd4);
        // BUSY with select, and NONSEQ without select, are ignored
        bus.hSSel   = 1'b1;
        bus.hSAddr  = 32'h0000_0200;
        bus.hSTrans = HTRANS_BUSY;
        @(posedge clk);
        #1;
        bus.hSSel   = 1'b0;
        bus.hSTrans = HTRANS_NONSEQ;
        @(negedge clk);
        check("busy_ignored", {60'd0, bus.hSReadyOut, bus.hSResp, strobe}, {60'd0, 4'b1000});
        @(posedge clk);
        #1;
        bus.hSTrans = HTRANS_IDLE;
        @(negedge clk);
        check("unsel_ignored", {60'd0, bus.hSReadyOut, bus.hSResp, strobe}, {60'd0, 4'b1000});
        @(posedge clk);
        #1;
        // Long wait: timeout build forces ERROR, default build waits it out
`ifdef RW_AHBS_TIMEOUT_EN
        issue(32'h0000_0200, 1'b0, HSIZE_WORD, 32'h0, 1000, 1'b0, 32'h5A5A_0001,
              4'b1111, 8, HRESP_ERROR, 32'h0, 9, 1'b1);
`else
        issue(32'h0000_0200, 1'b0, HSIZE_WORD, 32'h0, 20, 1'b0, 32'h5A5A_0001,
              4'b1111, 21, HRESP_OKAY, 32'h5A5A_0001, 20, 1'b0);
`endif
        drain();
        // Reset in the middle of the third of three reads
        issue(32'h0000_0300, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h1111_1111,
              4'b1111, 1, HRESP_OKAY, 32'h1111_1111, 0, 1'b0);
        issue(32'h0000_0304, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h2222_2222,
              4'b1111, 1, HRESP_OKAY, 32'h2222_2222, 0, 1'b0);
        issue(32'h0000_0308, 1'b0, HSIZE_WORD, 32'h0, 6, 1'b0, 32'h3333_3333,
              4'b1111, 7, HRESP_OKAY, 32'h3333_3333, 6, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
